// File: rtl/mem_pkg.sv
// Shared state encoding, access-length codes and I/O region helpers for mem_ctrl.
package mem_pkg;
   typedef enum logic [1:0] {IDLE, IREAD, DREAD, DWRITE} state_t;

   localparam logic [1:0]  LEN_B   = 2'd0;
   localparam logic [1:0]  LEN_H   = 2'd1;
   localparam logic [1:0]  LEN_W   = 2'd2;
   localparam logic [31:0] IO_BASE = 32'h30000;

   // Index of the final byte lane; length code 3 behaves as a word.
   function automatic logic [1:0] last_idx(input logic [1:0] len);
      case (len)
         LEN_B:   return 2'd0;
         LEN_H:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic is_io(input logic [1:0] sel);
      return sel == IO_BASE[17:16];
   endfunction
endpackage

// File: rtl/load_ext.sv
// Sign/zero extension of an assembled little-endian load value to 32 bits.
module load_ext
   import mem_pkg::*;
(
   input  logic [31:0] raw_i,
   input  logic [1:0]  len_i,
   input  logic        sgn_i,
   output logic [31:0] ext_o
);
   always_comb begin
      ext_o = raw_i;
      case (len_i)
         LEN_B:   ext_o = {{24{sgn_i & raw_i[7]}}, raw_i[7:0]};
         LEN_H:   ext_o = {{16{sgn_i & raw_i[15]}}, raw_i[15:0]};
         default: ext_o = raw_i;
      endcase
   end
endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating I-fetch and D-access onto a byte bus.
// Optional MEM_CTRL_IO_STALL_EN: hold I/O-region store bytes while io_buffer_full is set.
module mem_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_abort,
   output logic              i_ready,
   output logic [31:0]       i_data,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [1:0]        d_len,
   input  logic              d_signed,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ready,
   output logic [31:0]       d_rdata,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);
   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d, cap_lane_q, cap_lane_d, len_q, len_d;
   logic              done_q, done_d, cap_vld_q, cap_vld_d, sgn_q, sgn_d;
   logic              i_ready_q, i_ready_d, d_ready_q, d_ready_d;
   logic [ADDR_W-1:0] addr_q, addr_d, cur_addr, cap_addr;
   logic [31:0]       wdata_q, wdata_d, lanes_q, lanes_d, lanes_cap;
   logic [31:0]       i_data_q, i_data_d, d_rdata_q, d_rdata_d, ext_word;
   logic              io_hit, io_stall;

   assign cur_addr = addr_q + ADDR_W'(cnt_q);
   assign cap_addr = addr_q + ADDR_W'(cap_lane_q);
   assign io_hit   = is_io(cur_addr[17:16]);

`ifdef MEM_CTRL_IO_STALL_EN
   assign io_stall = (state_q == DWRITE) && io_hit && io_buffer_full;
`else
   logic unused_io;
   assign unused_io = io_hit & io_buffer_full;
   assign io_stall  = 1'b0;
`endif

   // The byte returned for the previously issued address lands in its lane.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes_cap[8*gi +: 8] = (cap_vld_q && cap_lane_q == 2'(gi)) ? mem_din
                                                                          : lanes_q[8*gi +: 8];
   end

   load_ext u_load_ext (
      .raw_i (lanes_cap),
      .len_i (len_q),
      .sgn_i (sgn_q),
      .ext_o (ext_word)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      done_d     = done_q;
      cap_vld_d  = 1'b0;
      cap_lane_d = cap_lane_q;
      addr_d     = addr_q;
      len_d      = len_q;
      sgn_d      = sgn_q;
      wdata_d    = wdata_q;
      lanes_d    = lanes_cap;
      i_data_d   = i_data_q;
      d_rdata_d  = d_rdata_q;
      i_ready_d  = 1'b0;
      d_ready_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d  = 2'd0;
            done_d = 1'b0;
            if (d_req) begin
               state_d = d_wr ? DWRITE : DREAD;
               addr_d  = d_addr;
               len_d   = d_len;
               sgn_d   = d_signed;
               wdata_d = d_wdata;
               lanes_d = '0;
            end else if (i_req && !i_abort) begin
               state_d = IREAD;
               addr_d  = i_addr;
               len_d   = LEN_W;
               sgn_d   = 1'b0;
               lanes_d = '0;
            end
         end
         IREAD, DREAD: begin
            if (!done_q) begin
               cap_vld_d  = 1'b1;
               cap_lane_d = cnt_q;
               if (cnt_q == last_idx(len_q)) done_d = 1'b1;
               else                          cnt_d  = cnt_q + 2'd1;
            end else begin
               // All addresses issued; this cycle captures the final byte.
               state_d = IDLE;
               if (state_q == IREAD) begin
                  i_data_d  = lanes_cap;
                  i_ready_d = 1'b1;
               end else begin
                  d_rdata_d = ext_word;
                  d_ready_d = 1'b1;
               end
            end
            if (state_q == IREAD && i_abort) begin
               state_d   = IDLE;
               cap_vld_d = 1'b0;
               i_ready_d = 1'b0;
               i_data_d  = i_data_q;
            end
         end
         DWRITE: begin
            if (!io_stall) begin
               if (cnt_q == last_idx(len_q)) begin
                  state_d   = IDLE;
                  d_ready_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         cap_vld_q  <= 1'b0;
         cap_lane_q <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         sgn_q      <= 1'b0;
         wdata_q    <= '0;
         lanes_q    <= '0;
         i_data_q   <= '0;
         d_rdata_q  <= '0;
         i_ready_q  <= 1'b0;
         d_ready_q  <= 1'b0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         cap_vld_q  <= cap_vld_d;
         cap_lane_q <= cap_lane_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         sgn_q      <= sgn_d;
         wdata_q    <= wdata_d;
         lanes_q    <= lanes_d;
         i_data_q   <= i_data_d;
         d_rdata_q  <= d_rdata_d;
         i_ready_q  <= i_ready_d;
         d_ready_q  <= d_ready_d;
      end
   end

   // While paused with a byte outstanding, keep presenting its address so the
   // memory returns it again in the first cycle after the pause.
   always_comb begin
      mem_a    = '0;
      mem_dout = '0;
      mem_wr   = 1'b0;
      case (state_q)
         IREAD, DREAD: begin
            if (!rdy_in && cap_vld_q) mem_a = cap_addr;
            else if (!done_q)         mem_a = cur_addr;
         end
         DWRITE: begin
            mem_a    = cur_addr;
            mem_dout = wdata_q[{cnt_q, 3'b000} +: 8];
            mem_wr   = rdy_in && !io_stall;
         end
         default: ;
      endcase
   end

   assign i_ready = i_ready_q & ~i_abort;
   assign i_data  = i_data_q;
   assign d_ready = d_ready_q;
   assign d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a one-cycle-latency byte memory model.
module tb_mem_ctrl;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        i_req, i_abort, i_ready;
   logic [31:0] i_addr, i_data;
   logic        d_req, d_wr, d_signed, d_ready;
   logic [1:0]  d_len;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, io_buffer_full;

   int checks = 0;
   int errors = 0;
   int cyc;

   logic [7:0]  mem [0:4095];
   logic [31:0] a_log [0:15];
   logic        w_log [0:15];
   logic [7:0]  o_log [0:15];

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort), .i_ready(i_ready), .i_data(i_data),
      .d_req(d_req), .d_wr(d_wr), .d_len(d_len), .d_signed(d_signed), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   always #5 clk_in = ~clk_in;

   // Byte memory: read data appears the cycle after its address; preloaded during reset.
   always @(posedge clk_in) begin
      if (rst_in) begin
         mem[12'h100] <= 8'h13; mem[12'h101] <= 8'h05; mem[12'h102] <= 8'h10; mem[12'h103] <= 8'h00;
         mem[12'h200] <= 8'h80;
         mem[12'h210] <= 8'h34; mem[12'h211] <= 8'hF2;
         mem[12'h400] <= 8'h11; mem[12'h401] <= 8'h22; mem[12'h402] <= 8'h33; mem[12'h403] <= 8'h44;
         mem[12'hFFF] <= 8'hAA; mem[12'h000] <= 8'hBB; mem[12'h001] <= 8'hCC; mem[12'h002] <= 8'hDD;
      end else if (mem_wr) begin
         mem[mem_a[11:0]] <= mem_dout;
      end
      mem_din <= mem[mem_a[11:0]];
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Runs one transaction from the IDLE cycle; bit c of each mask applies in cycle Cc.
   task automatic run_txn(input bit is_d, input logic [15:0] pause_m, input logic [15:0] abort_m,
                          input logic [15:0] io_m, input int max_cyc, output int n);
      n = 0;
      for (int c = 0; c < 16; c++) begin
         a_log[c] = '0; w_log[c] = 1'b0; o_log[c] = '0;
      end
      for (int c = 1; c <= max_cyc; c++) begin
         tick();
         rdy_in         = ~pause_m[c];
         i_abort        = abort_m[c];
         io_buffer_full = io_m[c];
         if (abort_m[c]) i_req = 1'b0;
         #1;
         a_log[c] = mem_a; w_log[c] = mem_wr; o_log[c] = mem_dout;
         if (is_d ? d_ready : i_ready) begin
            n = c;
            break;
         end
      end
      if (is_d) d_req = 1'b0;
      else      i_req = 1'b0;
      rdy_in = 1'b1; i_abort = 1'b0; io_buffer_full = 1'b0;
      $display("txn side=%s cycles=%0d i_data=0x%08h d_rdata=0x%08h", is_d ? "D" : "I", n, i_data, d_rdata);
   endtask

   task automatic set_d(input bit wr, input logic [1:0] len, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
      d_req = 1'b1; d_wr = wr; d_len = len; d_signed = sgn; d_addr = addr; d_wdata = wdata;
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; i_req = 1'b0; i_addr = '0; i_abort = 1'b0;
      d_req = 1'b0; d_wr = 1'b0; d_len = '0; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
      io_buffer_full = 1'b0;
      tick(); tick();
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
      chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
      chk("rst_i_ready", {31'b0, i_ready}, 32'h0);
      chk("rst_d_ready", {31'b0, d_ready}, 32'h0);
      chk("rst_i_data", i_data, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      rst_in = 1'b0;
      tick();

      // Word fetch: addresses in C1..C4, ready in C6.
      i_req = 1'b1; i_addr = 32'h100;
      run_txn(1'b0, 16'h0, 16'h0, 16'h0, 12, cyc);
      chk("fetch_cycles", cyc, 6);
      chk("fetch_a1", a_log[1], 32'h100);
      chk("fetch_a4", a_log[4], 32'h103);
      chk("fetch_data", i_data, 32'h00100513);
      tick();
      chk("fetch_pulse_end", {31'b0, i_ready}, 32'h0);
      chk("idle_mem_a", mem_a, 32'h0);

      // Byte loads, signed then unsigned: ready in C3.
      set_d(1'b0, 2'd0, 1'b1, 32'h200, 32'h0);
      run_txn(1'b1, 16'h0, 16'h0, 16'h0, 12, cyc);
      chk("lb_cycles", cyc, 3);
      chk("lb_a1", a_log[1], 32'h200);
      chk("lb_signed", d_rdata, 32'hFFFFFF80);
      set_d(1'b0, 2'd0, 1'b0, 32'h200, 32'h0);
      run_txn(1'b1, 16'h0, 16'h0, 16'h0, 12, cyc);
      chk("lbu_cycles", cyc, 3);
      chk("lbu_data", d_rdata, 32'h00000080);

      // Word store: one byte per cycle C1..C4, ready in C5.
      set_d(1'b1, 2'd2, 1'b0, 32'h300, 32'hDEADBEEF);
      run_txn(1'b1, 16'h0, 16'h0, 16'h0, 12, cyc);
      chk("sw_cycles", cyc, 5);
      chk("sw_a1", a_log[1], 32'h300);
      chk("sw_a4", a_log[4], 32'h303);
      chk("sw_d1", {24'b0, o_log[1]}, 32'hEF);
      chk("sw_d4", {24'b0, o_log[4]}, 32'hDE);
      chk("sw_wr", {28'b0, w_log[1], w_log[2], w_log[3], w_log[4]}, 32'hF);
      chk("sw_wr_ready_cycle", {31'b0, w_log[5]}, 32'h0);
      chk("sw_mem", {mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]}, 32'hDEADBEEF);

      // D and I requested together: D first, I starts the cycle after d_ready.
      i_req = 1'b1; i_addr = 32'h100;
      set_d(1'b0, 2'd1, 1'b1, 32'h210, 32'h0);
      run_txn(1'b1, 16'h0, 16'h0, 16'h0, 12, cyc);
      chk("arb_d_cycles", cyc, 4);
      chk("arb_d_a1", a_log[1], 32'h210);
      chk("arb_lh_signed", d_rdata, 32'hFFFFF234);
      run_txn(1'b0, 16'h0, 16'h0, 16'h0, 12, cyc);
      chk("arb_i_cycles", cyc, 6);
      chk("arb_i_a1", a_log[1], 32'h100);
      chk("arb_i_data", i_data, 32'h00100513);

      set_d(1'b0, 2'd1, 1'b0, 32'h210, 32'h0);
      run_txn(1'b1, 16'h0, 16'h0, 16'h0, 12, cyc);
      chk("lhu_data", d_rdata, 32'h0000F234);

      // Abort in C2: no i_ready, IDLE outputs from C3.
      i_req = 1'b1; i_addr = 32'h100;
      run_txn(1'b0, 16'h0, 16'h0004, 16'h0, 9, cyc);
      chk("abort_no_ready", cyc, 0);
      chk("abort_a2", a_log[2], 32'h101);
      chk("abort_idle_a3", a_log[3], 32'h0);

      // Length code 3 is a word; address wraps at 2^32.
      set_d(1'b0, 2'd3, 1'b1, 32'h400, 32'h0);
      run_txn(1'b1, 16'h0, 16'h0, 16'h0, 12, cyc);
      chk("len3_cycles", cyc, 6);
      chk("len3_data", d_rdata, 32'h44332211);
      set_d(1'b0, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h0);
      run_txn(1'b1, 16'h0, 16'h0, 16'h0, 12, cyc);
      chk("wrap_a1", a_log[1], 32'hFFFFFFFF);
      chk("wrap_a2", a_log[2], 32'h0);
      chk("wrap_data", d_rdata, 32'hDDCCBBAA);

      // rdy_in low in C3,C4 of a word read: same data, ready two cycles later.
      set_d(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
      run_txn(1'b1, 16'h0018, 16'h0, 16'h0, 14, cyc);
      chk("pause_rd_cycles", cyc, 8);
      chk("pause_rd_data", d_rdata, 32'h44332211);

      // rdy_in low in C2 of a word store: no write that cycle.
      set_d(1'b1, 2'd2, 1'b0, 32'h310, 32'h12345678);
      run_txn(1'b1, 16'h0004, 16'h0, 16'h0, 14, cyc);
      chk("pause_wr_cycles", cyc, 6);
      chk("pause_wr_gap", {31'b0, w_log[2]}, 32'h0);
      chk("pause_wr_a3", a_log[3], 32'h311);
      chk("pause_wr_mem", {mem[12'h313], mem[12'h312], mem[12'h311], mem[12'h310]}, 32'h12345678);

      // Reset during a store: bus outputs drop at once.
      set_d(1'b1, 2'd2, 1'b0, 32'h320, 32'hCAFEF00D);
      tick(); tick();
      chk("midrst_pre_wr", {31'b0, mem_wr}, 32'h1);
      chk("midrst_pre_a", mem_a, 32'h321);
      rst_in = 1'b1;
      #1;
      chk("midrst_wr", {31'b0, mem_wr}, 32'h0);
      chk("midrst_a", mem_a, 32'h0);
      chk("midrst_dout", {24'b0, mem_dout}, 32'h0);
      d_req = 1'b0;
      tick();
      rst_in = 1'b0;
      tick();

      // Byte store to the I/O region with the buffer full in C1..C3.
      set_d(1'b1, 2'd0, 1'b0, 32'h30000, 32'h000000A5);
      run_txn(1'b1, 16'h0, 16'h0, 16'h000E, 12, cyc);
`ifdef MEM_CTRL_IO_STALL_EN
      chk("io_cycles", cyc, 5);
      chk("io_held", {29'b0, w_log[1], w_log[2], w_log[3]}, 32'h0);
      chk("io_write", {31'b0, w_log[4]}, 32'h1);
`else
      chk("io_cycles", cyc, 2);
      chk("io_write", {31'b0, w_log[1]}, 32'h1);
`endif
      chk("io_mem", {24'b0, mem[12'h000]}, 32'hA5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the CPU's instruction cache / load-store path and the external byte-wide memory bus. It serializes 32-bit instruction fetches and 8/16/32-bit data loads and stores into per-byte bus cycles, pipelining reads against the one-cycle memory latency. It arbitrates between the I-side and the D-side, and drives `mem_a`/`mem_dout`/`mem_wr` for the `cpu` top.

## Interface
Parameters:
- `ADDR_W`, 32: address width on all ports.

Ports:
- `clk_in` input 1: the single clock; all state changes on its rising edge.
- `rst_in` input 1: asynchronous, active-high reset.
- `rdy_in` input 1: when low, freeze all state and force `mem_wr`=0.
- `i_req` input 1: instruction fetch request; held with `i_addr` until `i_ready`.
- `i_addr` input 32: fetch address (word).
- `i_abort` input 1: cancel an in-flight or pending fetch (branch flush).
- `i_ready` output 1: one-cycle pulse, `i_data` valid.
- `i_data` output 32: little-endian fetched word.
- `d_req` input 1: data request; held with the other `d_*` inputs until `d_ready`.
- `d_wr` input 1: 1 = store, 0 = load.
- `d_len` input 2: 0 = byte, 1 = half, 2 = word.
- `d_signed` input 1: sign-extend load result.
- `d_addr` input 32: data address.
- `d_wdata` input 32: store data; low bytes are used.
- `d_ready` output 1: one-cycle pulse, access complete.
- `d_rdata` output 32: load result, extended to 32 bits.
- `mem_din` input 8: memory read byte, valid the cycle after its address.
- `mem_dout` output 8: write byte.
- `mem_a` output 32: byte address.
- `mem_wr` output 1: 1 = write.
- `io_buffer_full` input 1: UART TX buffer full.

## Operation
- FSM states: IDLE, IREAD, DREAD, DWRITE. Byte counter `cnt`, 0..3.
- Arbitration in IDLE:
  - If `d_req` is high, enter DREAD or DWRITE, per `d_wr`.
  - Otherwise, if `i_req && !i_abort`, enter IREAD.
  - D-side has fixed priority. There is no preemption once a transaction starts.
- Byte count N = 1/2/4 for `d_len` 0/1/2. IREAD always uses N = 4. `d_len`=3 is treated as word.
- Reads:
  - Issue `mem_a` = addr+k for k = 0..N-1 on consecutive cycles.
  - Capture `mem_din` one cycle after each address into byte lane k.
- Writes: drive `mem_a` = addr+k, `mem_dout` = `d_wdata[8k+7:8k]`, `mem_wr`=1 for k = 0..N-1. One byte per cycle; no wait for data.
- Load extension:
  - Byte result: bit 7 extended if `d_signed`, else zero-extended.
  - Half result: bit 15 extended if `d_signed`, else zero-extended.
  - Word result: unchanged.
- Address arithmetic is 32-bit, wrapping at 2^32. Alignment is not checked.
- `i_abort` in IREAD: return to IDLE at the next edge and discard captured bytes. No `i_ready` is produced. A memory byte already in flight is ignored.
- `i_ready` is gated by `!i_abort` in its completion cycle.
- `i_abort` has no effect on D-side transactions.
- Idle outputs: `mem_a`=0, `mem_wr`=0, `mem_dout`=0.

## Timing
- Request sampled at edge E0 (state IDLE). Address cycles are C1..CN.
- Reads: last byte is captured at the end of C(N+1). The ready pulse and data are valid in C(N+2).
  - Word read: ready in C6.
  - Byte read: ready in C3.
- Writes: `d_ready` in C(N+1).
  - Word store: ready in C5.
  - Byte store: ready in C2.
- The FSM is back in IDLE during the ready cycle, so a new request can be sampled at the end of that cycle. The requester must drop or renew `req` in that same cycle.
- `rdy_in` low: FSM, counter, and captured lanes hold. `mem_wr`=0.
  - A read byte returned during a pause is not re-captured. Instead, the address for the pending byte is reissued when `rdy_in` returns.
- Reset mid-transaction: all outputs go to 0 immediately and the FSM returns to IDLE. Reset value of every output is 0.
- Simultaneous `i_req` and `d_req` in IDLE: D is served first; I is served in the cycle after `d_ready`.

## Configuration
- `MEM_CTRL_IO_STALL_EN` defined: a DWRITE byte to an address with `addr[17:16]`==2'b11 is held while `io_buffer_full`=1. `mem_wr` stays 0 and `cnt` does not advance until the flag clears.
- Not defined: `io_buffer_full` is ignored and I/O writes proceed at one byte per cycle.

## Structure
- Shared package `mem_pkg`:
  - FSM state enum.
  - `d_len` encodings (`LEN_B`, `LEN_H`, `LEN_W`).
  - `IO_BASE` = 32'h30000.
- One sub-module, `load_ext`: combinational byte/half/word sign/zero extension of the assembled load value.

## Test plan
- Word fetch `i_addr`=0x100, memory bytes 0x13,0x05,0x10,0x00 → `mem_a` 0x100..0x103 in C1..C4; `i_ready` in C6 with `i_data`=0x00100513.
- Signed byte load `d_addr`=0x200 holding 0x80, `d_signed`=1 → `d_ready` in C3, `d_rdata`=0xFFFFFF80. Repeat with `d_signed`=0 → 0x00000080.
- Word store `d_addr`=0x300, `d_wdata`=0xDEADBEEF → writes 0xEF,0xBE,0xAD,0xDE to 0x300..0x303 with `mem_wr`=1 in C1..C4; `d_ready` in C5.
- `i_req` and `d_req` both high in IDLE → D transaction completes first; the I fetch starts the cycle after `d_ready`. `i_abort` asserted in C2 of a fetch → no `i_ready`, IDLE next cycle.
- With `MEM_CTRL_IO_STALL_EN`: byte store to 0x30000 while `io_buffer_full`=1 for 3 cycles → `mem_wr` stays 0 for 3 cycles, then writes; `d_ready` follows one cycle later. `rdy_in` low for 2 cycles mid word read → result unchanged, ready delayed by 2 cycles.
